// File: rtl/mac_frame_scheduler.sv
// mac_frame_scheduler: arbitrates NUM_REQ descriptor sources onto a single MAC
// frame generator. Latches the winning header, pulses start, waits for done
// under a watchdog, then holds off for an inter-frame gap.
// Optional feature macro: MAC_SCHED_STRICT_PRIO_EN (lowest index always wins).
module mac_frame_scheduler #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned PAYLOAD_MAX_SIZE = 1500,
  parameter int unsigned IFG_CYCLES       = 3,
  parameter int unsigned TIMEOUT_CYCLES   = 512
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*48-1:0]      i_req_dest_addr,
  input  logic [NUM_REQ*48-1:0]      i_req_src_addr,
  input  logic [NUM_REQ*16-1:0]      i_req_eth_type,
  input  logic [NUM_REQ*16-1:0]      i_req_payload_length,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_gen_start,
  output logic [47:0]                o_gen_dest_addr,
  output logic [47:0]                o_gen_src_addr,
  output logic [15:0]                o_gen_eth_type,
  output logic [15:0]                o_gen_payload_length,
  input  logic                       i_gen_done,
  output logic                       o_busy,
  output logic                       o_frame_sent,
  output logic                       o_drop,
  output logic                       o_timeout,
  output logic                       o_err,
  output logic [31:0]                o_frame_count,
  output logic [$clog2(NUM_REQ)-1:0] o_cur_src
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'((IFG_CYCLES > 0) ? (IFG_CYCLES - 1) : 0);
  localparam logic             HAS_IFG  = (IFG_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_IFG       = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WD_W-1:0]  wd_q, wd_d;
  logic [IFG_W-1:0] ifg_q, ifg_d;

  logic [SRC_W-1:0] win_idx;
  logic             arb_fire;
  logic [47:0]      win_dest;
  logic [47:0]      win_src;
  logic [15:0]      win_type;
  logic [15:0]      win_len;

  logic [NUM_REQ-1:0] grant_d;
  logic               start_d;
  logic [47:0]        dest_d;
  logic [47:0]        src_d;
  logic [15:0]        type_d;
  logic [15:0]        len_d;
  logic               busy_d;
  logic               sent_d;
  logic               drop_d;
  logic               timeout_d;
  logic               err_d;
  logic [31:0]        count_d;
  logic [SRC_W-1:0]   cur_d;

  // An arbitration happens only from IDLE while enabled with a pending request
  assign arb_fire = (state_q == S_IDLE) && i_enable && (|i_req);

`ifdef MAC_SCHED_STRICT_PRIO_EN
  // Fixed priority: lowest-index requesting source wins
  always_comb begin
    win_idx = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (i_req[SRC_W'(i)]) win_idx = SRC_W'(i);
    end
  end
`else
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] cand;
  logic             found;

  // Round-robin: first requester found searching upward from rr_ptr with wrap
  always_comb begin
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = SRC_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && i_req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  // Pointer moves past every granted source, accepted or dropped
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr <= '0;
    end else if (arb_fire) begin
      rr_ptr <= (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
    end
  end
`endif

  // Select the winner's descriptor fields out of the packed source buses
  always_comb begin
    win_dest = '0;
    win_src  = '0;
    win_type = '0;
    win_len  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win_idx == SRC_W'(k)) begin
        win_dest = i_req_dest_addr[k*48 +: 48];
        win_src  = i_req_src_addr[k*48 +: 48];
        win_type = i_req_eth_type[k*16 +: 16];
        win_len  = i_req_payload_length[k*16 +: 16];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    ifg_d     = ifg_q;
    grant_d   = '0;
    start_d   = 1'b0;
    sent_d    = 1'b0;
    drop_d    = 1'b0;
    timeout_d = 1'b0;
    err_d     = o_err;
    count_d   = o_frame_count;
    cur_d     = o_cur_src;
    dest_d    = o_gen_dest_addr;
    src_d     = o_gen_src_addr;
    type_d    = o_gen_eth_type;
    len_d     = o_gen_payload_length;

    case (state_q)
      S_IDLE: begin
        if (arb_fire) begin
          grant_d = NUM_REQ'(1) << win_idx;
          cur_d   = win_idx;
          if (win_len > 16'(PAYLOAD_MAX_SIZE)) begin
            drop_d = 1'b1;
          end else begin
            dest_d  = win_dest;
            src_d   = win_src;
            type_d  = win_type;
            len_d   = win_len;
            state_d = S_START;
          end
        end
      end

      S_START: begin
        start_d = 1'b1;
        wd_d    = '0;
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        ifg_d = '0;
        if (i_gen_done) begin
          sent_d  = 1'b1;
          count_d = o_frame_count + 32'd1;
          state_d = HAS_IFG ? S_IFG : S_IDLE;
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          err_d     = 1'b1;
          state_d   = HAS_IFG ? S_IFG : S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      S_IFG: begin
        if (ifg_q == IFG_LAST) begin
          state_d = S_IDLE;
        end else begin
          ifg_d = ifg_q + IFG_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q              <= S_IDLE;
      wd_q                 <= '0;
      ifg_q                <= '0;
      o_grant              <= '0;
      o_gen_start          <= 1'b0;
      o_gen_dest_addr      <= '0;
      o_gen_src_addr       <= '0;
      o_gen_eth_type       <= '0;
      o_gen_payload_length <= '0;
      o_busy               <= 1'b0;
      o_frame_sent         <= 1'b0;
      o_drop               <= 1'b0;
      o_timeout            <= 1'b0;
      o_err                <= 1'b0;
      o_frame_count        <= '0;
      o_cur_src            <= '0;
    end else begin
      state_q              <= state_d;
      wd_q                 <= wd_d;
      ifg_q                <= ifg_d;
      o_grant              <= grant_d;
      o_gen_start          <= start_d;
      o_gen_dest_addr      <= dest_d;
      o_gen_src_addr       <= src_d;
      o_gen_eth_type       <= type_d;
      o_gen_payload_length <= len_d;
      o_busy               <= busy_d;
      o_frame_sent         <= sent_d;
      o_drop               <= drop_d;
      o_timeout            <= timeout_d;
      o_err                <= err_d;
      o_frame_count        <= count_d;
      o_cur_src            <= cur_d;
    end
  end

endmodule

// File: tb/tb_mac_frame_scheduler.sv
// Testbench for mac_frame_scheduler: randomized descriptors checked against a
// transaction-level reference model (winner pick, timing, counters, sticky error).
module tb_mac_frame_scheduler;

  localparam int N      = 4;
  localparam int SW     = $clog2(N);
  localparam int MAXLEN = 1500;
  localparam int IFG    = 3;
  localparam int TMO    = 512;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_enable = 1'b0;
  logic [N-1:0]      i_req = '0;
  logic [N*48-1:0]   i_req_dest_addr = '0;
  logic [N*48-1:0]   i_req_src_addr = '0;
  logic [N*16-1:0]   i_req_eth_type = '0;
  logic [N*16-1:0]   i_req_payload_length = '0;
  logic              i_gen_done = 1'b0;
  logic [N-1:0]      o_grant;
  logic              o_gen_start;
  logic [47:0]       o_gen_dest_addr;
  logic [47:0]       o_gen_src_addr;
  logic [15:0]       o_gen_eth_type;
  logic [15:0]       o_gen_payload_length;
  logic              o_busy;
  logic              o_frame_sent;
  logic              o_drop;
  logic              o_timeout;
  logic              o_err;
  logic [31:0]       o_frame_count;
  logic [SW-1:0]     o_cur_src;

  mac_frame_scheduler #(
    .NUM_REQ(N), .PAYLOAD_MAX_SIZE(MAXLEN), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_req(i_req),
    .i_req_dest_addr(i_req_dest_addr), .i_req_src_addr(i_req_src_addr),
    .i_req_eth_type(i_req_eth_type), .i_req_payload_length(i_req_payload_length),
    .o_grant(o_grant), .o_gen_start(o_gen_start),
    .o_gen_dest_addr(o_gen_dest_addr), .o_gen_src_addr(o_gen_src_addr),
    .o_gen_eth_type(o_gen_eth_type), .o_gen_payload_length(o_gen_payload_length),
    .i_gen_done(i_gen_done), .o_busy(o_busy), .o_frame_sent(o_frame_sent),
    .o_drop(o_drop), .o_timeout(o_timeout), .o_err(o_err),
    .o_frame_count(o_frame_count), .o_cur_src(o_cur_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_ptr = 0;
  int unsigned m_count = 0;
  logic        m_err = 1'b0;
  logic [47:0] m_dest = '0;
  logic [47:0] m_src = '0;
  logic [15:0] m_type = '0;
  logic [15:0] m_len = '0;

  // Shadow copies of what each source is presenting
  logic [47:0] dest_a [N];
  logic [47:0] src_a  [N];
  logic [15:0] type_a [N];
  logic [15:0] len_a  [N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [15:0] len);
    dest_a[k] = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    src_a[k]  = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    type_a[k] = 16'($urandom());
    len_a[k]  = len;
    i_req_dest_addr[k*48 +: 48]    = dest_a[k];
    i_req_src_addr[k*48 +: 48]     = src_a[k];
    i_req_eth_type[k*16 +: 16]     = type_a[k];
    i_req_payload_length[k*16 +: 16] = len;
  endtask

  // Expected winner: first requester found going upward from the pointer
  function automatic int model_pick(input logic [N-1:0] r);
    model_pick = -1;
`ifdef MAC_SCHED_STRICT_PRIO_EN
    for (int i = N - 1; i >= 0; i--) if (r[i]) model_pick = i;
`else
    for (int i = N - 1; i >= 0; i--) if (r[(m_ptr + i) % N]) model_pick = (m_ptr + i) % N;
`endif
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_count = 0; m_err = 1'b0;
    m_dest = '0; m_src = '0; m_type = '0; m_len = '0;
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    model_reset();
  endtask

  // One arbitration from IDLE; done_dly < 0 means the generator never answers
  task automatic do_frame(input int done_dly, input bit keep_req);
    int         w;
    logic [N-1:0] exp_g;
    bit         bad;
    w = model_pick(i_req);
    step();
    exp_g = (w < 0) ? '0 : (N'(1) << w);
    checks++;
    if (o_grant !== exp_g) begin
      failures++; $display("FAIL grant: got %b expected %b", o_grant, exp_g);
    end
    checks++;
    if (o_gen_start !== 1'b0) begin
      failures++; $display("FAIL start_at_grant: got %b expected 0", o_gen_start);
    end
    if (w < 0) return;
    checks++;
    if (o_cur_src !== SW'(w)) begin
      failures++; $display("FAIL cur_src: got %0d expected %0d", o_cur_src, w);
    end
    if (!keep_req) i_req[w] = 1'b0;
`ifndef MAC_SCHED_STRICT_PRIO_EN
    m_ptr = (w + 1) % N;
`endif
    if (int'(len_a[w]) > MAXLEN) begin
      checks++;
      if ({o_drop, o_busy} !== 2'b10) begin
        failures++; $display("FAIL drop: got drop=%b busy=%b expected drop=1 busy=0", o_drop, o_busy);
      end
      checks++;
      if ({o_gen_dest_addr, o_gen_src_addr, o_gen_eth_type, o_gen_payload_length} !== {m_dest, m_src, m_type, m_len}) begin
        failures++; $display("FAIL drop_fields: got len=%0d dest=%h expected len=%0d dest=%h",
                             o_gen_payload_length, o_gen_dest_addr, m_len, m_dest);
      end
      return;
    end
    m_dest = dest_a[w]; m_src = src_a[w]; m_type = type_a[w]; m_len = len_a[w];
    checks++;
    if ({o_drop, o_busy} !== 2'b01) begin
      failures++; $display("FAIL accept: got drop=%b busy=%b expected drop=0 busy=1", o_drop, o_busy);
    end
    step();
    checks++;
    if (o_gen_start !== 1'b1 || o_grant !== '0) begin
      failures++; $display("FAIL start: got start=%b grant=%b expected start=1 grant=0", o_gen_start, o_grant);
    end
    checks++;
    if ({o_gen_dest_addr, o_gen_src_addr, o_gen_eth_type, o_gen_payload_length} !== {m_dest, m_src, m_type, m_len}) begin
      failures++; $display("FAIL fields: got %h %h %h %0d expected %h %h %h %0d",
                           o_gen_dest_addr, o_gen_src_addr, o_gen_eth_type, o_gen_payload_length,
                           m_dest, m_src, m_type, m_len);
    end
    bad = 1'b0;
    if (done_dly >= 0 && done_dly <= TMO - 1) begin
      repeat (done_dly) begin
        step();
        if (o_gen_start || o_frame_sent || o_timeout) bad = 1'b1;
      end
      i_gen_done = 1'b1;
      step();
      i_gen_done = 1'b0;
      m_count++;
      checks++;
      if (o_frame_sent !== 1'b1 || o_timeout !== 1'b0 || bad) begin
        failures++; $display("FAIL done: got sent=%b timeout=%b early_pulse=%b expected sent=1 timeout=0 early_pulse=0",
                             o_frame_sent, o_timeout, bad);
      end
    end else begin
      for (int j = 1; j <= TMO; j++) begin
        step();
        if (j < TMO && (o_timeout || o_frame_sent || o_gen_start)) bad = 1'b1;
      end
      m_err = 1'b1;
      checks++;
      if (o_timeout !== 1'b1 || o_frame_sent !== 1'b0 || bad) begin
        failures++; $display("FAIL timeout: got timeout=%b sent=%b early_pulse=%b expected timeout=1 sent=0 early_pulse=0",
                             o_timeout, o_frame_sent, bad);
      end
    end
    checks++;
    if (o_frame_count !== m_count || o_err !== m_err) begin
      failures++; $display("FAIL count_err: got count=%0d err=%b expected count=%0d err=%b",
                           o_frame_count, o_err, m_count, m_err);
    end
    bad = 1'b0;
    for (int k = 1; k <= IFG; k++) begin
      step();
      if (k < IFG && o_busy !== 1'b1) bad = 1'b1;
      if (o_frame_sent || o_timeout || o_grant != '0) bad = 1'b1;
    end
    checks++;
    if (o_busy !== 1'b0 || bad) begin
      failures++; $display("FAIL ifg: got busy=%b gap_violation=%b expected busy=0 gap_violation=0", o_busy, bad);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step();
    checks++;
    if ({o_grant, o_gen_start, o_gen_dest_addr, o_gen_src_addr, o_gen_eth_type, o_gen_payload_length,
         o_busy, o_frame_sent, o_drop, o_timeout, o_err, o_frame_count, o_cur_src} !== '0) begin
      failures++; $display("FAIL reset_outputs: got grant=%b busy=%b count=%0d expected all zero",
                           o_grant, o_busy, o_frame_count);
    end
    i_rst = 1'b0;
    i_enable = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    set_src(0, 16'd46);
    i_req = 4'b0001;
    do_frame(20, 1'b0);
  endtask

  task automatic test_round_robin();
    int exp_seq [5];
`ifdef MAC_SCHED_STRICT_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    apply_reset();
    for (int k = 0; k < N; k++) set_src(k, 16'($urandom_range(46, MAXLEN)));
    i_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      do_frame(5, 1'b1);
      checks++;
      if (o_cur_src !== SW'(exp_seq[n])) begin
        failures++; $display("FAIL rr_order[%0d]: got %0d expected %0d", n, o_cur_src, exp_seq[n]);
      end
    end
    i_req = '0;
    step();
  endtask

  task automatic test_drop();
    int exp_next;
    set_src(2, 16'd1501);
    i_req = 4'b0100;
    do_frame(0, 1'b0);
    set_src(0, 16'd60);
    set_src(1, 16'd1500);
    set_src(3, 16'd100);
    i_req = 4'b1011;
`ifdef MAC_SCHED_STRICT_PRIO_EN
    exp_next = 0;
`else
    exp_next = 3;
`endif
    do_frame(8, 1'b0);
    checks++;
    if (o_cur_src !== SW'(exp_next)) begin
      failures++; $display("FAIL after_drop_src: got %0d expected %0d", o_cur_src, exp_next);
    end
    while (i_req != '0) do_frame(4, 1'b0);
  endtask

  task automatic test_enable();
    bit bad;
    bad = 1'b0;
    i_enable = 1'b0;
    set_src(1, 16'd200);
    i_req = 4'b0010;
    repeat (4) begin
      step();
      if (o_grant != '0 || o_busy) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL enable_low: got activity=1 expected activity=0");
    end
    i_enable = 1'b1;
    do_frame(3, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < N; k++) begin
        if (!i_req[k] && ($urandom_range(0, 1) == 1)) begin
          if ($urandom_range(0, 5) == 0) set_src(k, 16'($urandom_range(MAXLEN + 1, 65535)));
          else set_src(k, 16'($urandom_range(0, MAXLEN)));
          i_req[k] = 1'b1;
        end
      end
      if (i_req == '0) begin
        set_src(it % N, 16'($urandom_range(46, MAXLEN)));
        i_req[it % N] = 1'b1;
      end
      do_frame($urandom_range(1, 40), 1'b0);
    end
    while (i_req != '0) do_frame(2, 1'b0);
  endtask

  task automatic test_done_at_expiry();
    set_src(1, 16'd64);
    i_req = 4'b0010;
    do_frame(TMO - 1, 1'b0);
    checks++;
    if (o_err !== 1'b0) begin
      failures++; $display("FAIL expiry_tie_err: got %b expected 0", o_err);
    end
  endtask

  task automatic test_timeout();
    set_src(3, 16'd512);
    i_req = 4'b1000;
    do_frame(-1, 1'b0);
    step();
    checks++;
    if (o_err !== 1'b1 || o_frame_count !== m_count || o_busy !== 1'b0) begin
      failures++; $display("FAIL timeout_after: got err=%b count=%0d busy=%b expected err=1 count=%0d busy=0",
                           o_err, o_frame_count, o_busy, m_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    set_src(0, 16'd300);
    i_req = 4'b0001;
    step();
    i_req = '0;
    step();
    repeat (3) step();
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_grant, o_gen_start, o_busy, o_frame_sent, o_err, o_frame_count, o_gen_payload_length} !== '0) begin
      failures++; $display("FAIL async_reset: got busy=%b count=%0d err=%b expected all zero",
                           o_busy, o_frame_count, o_err);
    end
    step();
    i_rst = 1'b0;
    model_reset();
    i_gen_done = 1'b1;
    step();
    i_gen_done = 1'b0;
    checks++;
    if ({o_frame_sent, o_busy, o_timeout} !== 3'b000 || o_frame_count !== 32'd0) begin
      failures++; $display("FAIL late_done: got sent=%b busy=%b count=%0d expected sent=0 busy=0 count=0",
                           o_frame_sent, o_busy, o_frame_count);
    end
    set_src(1, 16'd46);
    set_src(2, 16'd46);
    i_req = 4'b0110;
    do_frame(6, 1'b0);
    do_frame(6, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_enable();
    test_random();
    test_done_at_expiry();
    test_timeout();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so a stuck run still ends with a summary
  initial begin
    #2000000;
    failures++;
    $display("FAIL time_limit: got still running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
